// File: rtl/conv_window_if.sv
// Pixel-in / window-out bundle between the raster source, the window generator
// and the convolution stage.
interface conv_window_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3
);
  logic [DATA_WIDTH-1:0]                         pixel_in;
  logic                                          pixel_valid;
  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window;
  logic                                          window_valid;
  logic                                          frame_done;

  modport master (
    output pixel_in, pixel_valid,
    input  window, window_valid, frame_done
  );

  modport slave (
    input  pixel_in, pixel_valid,
    output window, window_valid, frame_done
  );
endinterface

// File: rtl/conv_window_generator.sv
// Raster-order sliding KxK window generator: K-1 line buffers feed the rightmost
// window column, and a FILL/STREAM FSM gates window_valid per frame.
module conv_window_generator #(
  parameter int COLUMN_SIZE = 28,
  parameter int ROW_SIZE    = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 16
) (
  input logic          clock,
  input logic          reset_n,
  conv_window_if.slave bus
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
  localparam int RW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(COLUMN_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_SIZE - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(K - 1);

  typedef enum logic {FILL, STREAM} state_t;

  state_t                state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  vld_p1;
  logic                  done_p1;
  logic                  col_last;
  logic                  last_pix;
  logic                  first_win;

  logic [DATA_WIDTH-1:0] line_buf [K-1][COLUMN_SIZE];
  logic [DATA_WIDTH-1:0] lb_feed  [K-1];
  logic [DATA_WIDTH-1:0] col_in   [K];
  logic [DATA_WIDTH-1:0] win_p1   [K][K];

  assign col_last  = (col == COL_LAST);
  assign last_pix  = col_last && (row == ROW_LAST);
  assign first_win = (col == COL_WIN0) && (row == ROW_WIN0);

  // Each line buffer is a COLUMN_SIZE-deep shift chain, so its tail is the
  // same column one row earlier; chaining them yields rows r-1 .. r-K+1.
  always_comb begin
    lb_feed[0] = bus.pixel_in;
    for (int k = 1; k < K - 1; k++) begin
      lb_feed[k] = line_buf[k-1][COLUMN_SIZE-1];
    end
    for (int r = 0; r < K - 1; r++) begin
      col_in[r] = line_buf[K-2-r][COLUMN_SIZE-1];
    end
    col_in[K-1] = bus.pixel_in;
  end

  always_ff @(posedge clock) begin
    if (bus.pixel_valid) begin
      for (int k = 0; k < K - 1; k++) begin
        line_buf[k][0] <= lb_feed[k];
        for (int i = 1; i < COLUMN_SIZE; i++) begin
          line_buf[k][i] <= line_buf[k][i-1];
        end
      end
    end
  end

  // p0 -> p1: raster counters, emission FSM and registered valid/done
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FILL;
      col     <= '0;
      row     <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      if (bus.pixel_valid) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) begin
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end
        case (state)
          FILL: begin
            if (first_win) begin
              vld_p1  <= 1'b1;
              done_p1 <= last_pix;
              state   <= last_pix ? FILL : STREAM;
            end
          end
          STREAM: begin
            vld_p1  <= 1'b1;
            done_p1 <= last_pix;
            if (last_pix) begin
              state <= FILL;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

  // p0 -> p1: window shifts left, column K-1 takes the buffered column plus the new pixel
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_p1[r][c] <= '0;
        end
      end
    end else if (bus.pixel_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_p1[r][c] <= win_p1[r][c+1];
        end
        win_p1[r][K-1] <= col_in[r];
      end
    end
  end

  assign bus.window_valid = vld_p1;
  assign bus.frame_done   = done_p1;

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign bus.window[DATA_WIDTH*(r*K+c) +: DATA_WIDTH] = win_p1[r][c];
    end
  end

endmodule

// File: tb/tb_conv_window_generator.sv
// Scoreboard bench for conv_window_generator: a 5x5/K=3 instance and a 4x3/K=2 instance.
module tb_conv_window_generator;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  conv_window_if #(.DATA_WIDTH(16), .KERNEL_SIZE(3)) ifa ();
  conv_window_if #(.DATA_WIDTH(16), .KERNEL_SIZE(2)) ifb ();

  conv_window_generator #(.COLUMN_SIZE(5), .ROW_SIZE(5), .KERNEL_SIZE(3), .DATA_WIDTH(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ifa)
  );
  conv_window_generator #(.COLUMN_SIZE(4), .ROW_SIZE(3), .KERNEL_SIZE(2), .DATA_WIDTH(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ifb)
  );

  typedef struct {
    logic         v;
    logic         dc;
    logic         fd;
    logic [143:0] w;
  } ent_t;

  ent_t         exp_a[$], exp_b[$];
  logic [143:0] em_a[$], em_b[$];
  logic         em_dc_a[$], em_fd_a[$], em_fd_b[$];
  int           n_cmp = 0, n_fail = 0;
  int           spur_a = 0, spur_b = 0;
  int           acc_cnt_a = 0, first_at_a = -1;
  logic         acc_a = 1'b0, acc_b = 1'b0;

  always @(posedge clock) begin
    acc_a <= ifa.pixel_valid && reset_n;
    acc_b <= ifb.pixel_valid && reset_n;
  end

  always @(negedge clock) begin
    ent_t e;
    if (reset_n) begin
      if (acc_a) begin
        acc_cnt_a++;
        n_cmp++;
        if (exp_a.size() == 0) begin
          n_fail++;
          $display("FAIL sb_a_underflow: got valid=%0b with no expected entry", ifa.window_valid);
        end else begin
          e = exp_a.pop_front();
          if (ifa.window_valid !== e.v || ifa.frame_done !== e.fd ||
              (e.v && !e.dc && 144'(ifa.window) !== e.w)) begin
            n_fail++;
            $display("FAIL sb_a pixel %0d: got v=%0b fd=%0b win=%h, required v=%0b fd=%0b win=%h",
                     acc_cnt_a - 1, ifa.window_valid, ifa.frame_done, ifa.window, e.v, e.fd, e.w);
          end
          if (ifa.window_valid) begin
            em_a.push_back(144'(ifa.window));
            em_dc_a.push_back(e.dc);
            em_fd_a.push_back(ifa.frame_done);
            if (first_at_a < 0) first_at_a = acc_cnt_a - 1;
          end
        end
      end else if (ifa.window_valid || ifa.frame_done) begin
        spur_a++;
      end
    end
  end

  always @(negedge clock) begin
    ent_t e;
    if (reset_n) begin
      if (acc_b) begin
        n_cmp++;
        if (exp_b.size() == 0) begin
          n_fail++;
          $display("FAIL sb_b_underflow: got valid=%0b with no expected entry", ifb.window_valid);
        end else begin
          e = exp_b.pop_front();
          if (ifb.window_valid !== e.v || ifb.frame_done !== e.fd ||
              (e.v && !e.dc && 144'(ifb.window) !== e.w)) begin
            n_fail++;
            $display("FAIL sb_b: got v=%0b fd=%0b win=%h, required v=%0b fd=%0b win=%h",
                     ifb.window_valid, ifb.frame_done, ifb.window, e.v, e.fd, e.w);
          end
          if (ifb.window_valid) begin
            em_b.push_back(144'(ifb.window));
            em_fd_b.push_back(ifb.frame_done);
          end
        end
      end else if (ifb.window_valid || ifb.frame_done) begin
        spur_b++;
      end
    end
  end

  function automatic logic [143:0] pack_win(input int n, input int base, input int offs[9]);
    logic [143:0] w = '0;
    for (int i = 0; i < n; i++) w[16*i +: 16] = 16'(base + offs[i]);
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_logs();
    exp_a.delete(); exp_b.delete();
    em_a.delete(); em_b.delete();
    em_dc_a.delete(); em_fd_a.delete(); em_fd_b.delete();
    spur_a = 0; spur_b = 0;
    acc_cnt_a = 0; first_at_a = -1;
  endtask

  // Drives one pixel of (r,c) to the selected instance and queues the expected result.
  task automatic drive_pix(input int sel, input int r, input int c, input int base);
    int   cs, rs, k;
    ent_t e;
    cs = (sel != 0) ? 4 : 5;
    rs = (sel != 0) ? 3 : 5;
    k  = (sel != 0) ? 2 : 3;
    e.v  = (r*cs + c) >= ((k-1)*cs + (k-1));
    e.dc = (c < k-1);
    e.fd = (r == rs-1) && (c == cs-1);
    e.w  = '0;
    if (e.v && !e.dc) begin
      for (int wr = 0; wr < k; wr++)
        for (int wc = 0; wc < k; wc++)
          e.w[16*(wr*k+wc) +: 16] = 16'(base + (r-k+1+wr)*cs + (c-k+1+wc));
    end
    if (sel == 0) begin
      ifa.pixel_in = 16'(base + r*cs + c); ifa.pixel_valid = 1'b1; exp_a.push_back(e);
    end else begin
      ifb.pixel_in = 16'(base + r*cs + c); ifb.pixel_valid = 1'b1; exp_b.push_back(e);
    end
    @(posedge clock);
    #1;
    ifa.pixel_valid = 1'b0;
    ifb.pixel_valid = 1'b0;
  endtask

  task automatic send_frame(input int sel, input int base, input bit gaps);
    int cs, rs;
    cs = (sel != 0) ? 4 : 5;
    rs = (sel != 0) ? 3 : 5;
    for (int r = 0; r < rs; r++)
      for (int c = 0; c < cs; c++) begin
        drive_pix(sel, r, c, base);
        if (gaps) idle($urandom_range(0, 4));
      end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ifa.pixel_in = '0; ifa.pixel_valid = 1'b0;
    ifb.pixel_in = '0; ifb.pixel_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp += 6;
    if (ifa.window !== '0)      begin n_fail++; $display("FAIL reset_a_window: got %h, required 0", ifa.window); end
    if (ifa.window_valid !== 0) begin n_fail++; $display("FAIL reset_a_valid: got %b, required 0", ifa.window_valid); end
    if (ifa.frame_done !== 0)   begin n_fail++; $display("FAIL reset_a_done: got %b, required 0", ifa.frame_done); end
    if (ifb.window !== '0)      begin n_fail++; $display("FAIL reset_b_window: got %h, required 0", ifb.window); end
    if (ifb.window_valid !== 0) begin n_fail++; $display("FAIL reset_b_valid: got %b, required 0", ifb.window_valid); end
    if (ifb.frame_done !== 0)   begin n_fail++; $display("FAIL reset_b_done: got %b, required 0", ifb.frame_done); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_fill_and_count(input string tag);
    int first_o[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int fd_cnt = 0;
    clear_logs();
    send_frame(0, 0, 1'b0);
    idle(2);
    n_cmp += 5;
    if (exp_a.size() != 0) begin n_fail++; $display("FAIL %s_pending: got %0d, required 0", tag, exp_a.size()); end
    if (first_at_a != 12)  begin n_fail++; $display("FAIL %s_first_at: got pixel %0d, required 12", tag, first_at_a); end
    if (em_a.size() != 13) begin n_fail++; $display("FAIL %s_count: got %0d, required 13", tag, em_a.size()); end
    foreach (em_fd_a[i]) fd_cnt += int'(em_fd_a[i]);
    if (fd_cnt != 1)       begin n_fail++; $display("FAIL %s_done_count: got %0d, required 1", tag, fd_cnt); end
    if (spur_a != 0)       begin n_fail++; $display("FAIL %s_spurious: got %0d, required 0", tag, spur_a); end
    if (em_a.size() >= 13) begin
      n_cmp += 3;
      if (em_a[0] !== pack_win(9, 0, first_o))
        begin n_fail++; $display("FAIL %s_first_win: got %h, required %h", tag, em_a[0], pack_win(9, 0, first_o)); end
      if (em_a[12] !== pack_win(9, 12, first_o))
        begin n_fail++; $display("FAIL %s_last_win: got %h, required %h", tag, em_a[12], pack_win(9, 12, first_o)); end
      if (em_fd_a[12] !== 1'b1)
        begin n_fail++; $display("FAIL %s_done_pos: got %b, required 1", tag, em_fd_a[12]); end
    end
  endtask

  task automatic test_gaps();
    int first_o[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    clear_logs();
    send_frame(0, 0, 1'b1);
    idle(2);
    n_cmp += 3;
    if (spur_a != 0)       begin n_fail++; $display("FAIL gaps_valid_in_gap: got %0d, required 0", spur_a); end
    if (em_a.size() != 13) begin n_fail++; $display("FAIL gaps_count: got %0d, required 13", em_a.size()); end
    if (exp_a.size() != 0) begin n_fail++; $display("FAIL gaps_pending: got %0d, required 0", exp_a.size()); end
    if (em_a.size() >= 13) begin
      n_cmp += 2;
      if (em_a[0] !== pack_win(9, 0, first_o))
        begin n_fail++; $display("FAIL gaps_first_win: got %h, required %h", em_a[0], pack_win(9, 0, first_o)); end
      if (em_a[12] !== pack_win(9, 12, first_o))
        begin n_fail++; $display("FAIL gaps_last_win: got %h, required %h", em_a[12], pack_win(9, 12, first_o)); end
    end
  endtask

  task automatic test_back_to_back();
    int first_o[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int cnt = 0;
    clear_logs();
    send_frame(0, 0, 1'b0);
    send_frame(0, 100, 1'b0);
    idle(2);
    n_cmp += 2;
    if (em_a.size() != 26) begin n_fail++; $display("FAIL b2b_count: got %0d, required 26", em_a.size()); end
    if (spur_a != 0)       begin n_fail++; $display("FAIL b2b_spurious: got %0d, required 0", spur_a); end
    if (em_a.size() >= 14) begin
      n_cmp++;
      if (em_a[13] !== pack_win(9, 100, first_o))
        begin n_fail++; $display("FAIL b2b_second_first: got %h, required %h", em_a[13], pack_win(9, 100, first_o)); end
    end
    // Downstream column counter: counts valids mod 5, restarts after frame_done.
    foreach (em_dc_a[i]) begin
      n_cmp++;
      if ((cnt >= 3) !== em_dc_a[i])
        begin n_fail++; $display("FAIL b2b_align win %0d: got slot %0d masked=%0b, required masked=%0b", i, cnt, cnt >= 3, em_dc_a[i]); end
      cnt = em_fd_a[i] ? 0 : (cnt + 1) % 5;
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    for (int i = 0; i < 17; i++) drive_pix(0, i / 5, i % 5, 0);
    n_cmp++;
    if (ifa.window_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_valid: got %b, required 1", ifa.window_valid); end
    reset_n = 1'b0;
    #1;
    n_cmp += 3;
    if (ifa.window !== '0)      begin n_fail++; $display("FAIL rst_mid_window: got %h, required 0", ifa.window); end
    if (ifa.window_valid !== 0) begin n_fail++; $display("FAIL rst_mid_valid: got %b, required 0", ifa.window_valid); end
    if (ifa.frame_done !== 0)   begin n_fail++; $display("FAIL rst_mid_done: got %b, required 0", ifa.frame_done); end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    test_fill_and_count("rst_mid");
  endtask

  task automatic test_param_sweep();
    int first_o[9] = '{0, 1, 4, 5, 0, 0, 0, 0, 0};
    int fd_cnt = 0;
    clear_logs();
    send_frame(1, 0, 1'b0);
    idle(2);
    foreach (em_fd_b[i]) fd_cnt += int'(em_fd_b[i]);
    n_cmp += 4;
    if (em_b.size() != 7)  begin n_fail++; $display("FAIL sweep_count: got %0d, required 7", em_b.size()); end
    if (fd_cnt != 1)       begin n_fail++; $display("FAIL sweep_done_count: got %0d, required 1", fd_cnt); end
    if (spur_b != 0)       begin n_fail++; $display("FAIL sweep_spurious: got %0d, required 0", spur_b); end
    if (exp_b.size() != 0) begin n_fail++; $display("FAIL sweep_pending: got %0d, required 0", exp_b.size()); end
    if (em_b.size() >= 1) begin
      n_cmp++;
      if (em_b[0] !== pack_win(4, 0, first_o))
        begin n_fail++; $display("FAIL sweep_first_win: got %h, required %h", em_b[0], pack_win(4, 0, first_o)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_and_count("stream");
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_generator.md
# conv_window_generator

Streaming sliding-window generator that sits directly upstream of the pipelined convolution stage. It accepts one pixel per valid cycle in row-major raster order, buffers K-1 previous image rows, and emits a packed KxK window each cycle in exactly the order the convolution stage expects. That stage counts every window_valid modulo COLUMN_SIZE and discards the K-1 row-wrap windows itself, so this block emits those windows too and does not filter them.

## Interface
- COLUMN_SIZE, 28: image width in pixels.
- ROW_SIZE, 28: image height in pixels.
- KERNEL_SIZE, 3: window edge K; 2 <= K <= min(COLUMN_SIZE, ROW_SIZE).
- DATA_WIDTH, 16: pixel width in bits (opaque, no arithmetic performed).

- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- pixel_in  in  DATA_WIDTH  incoming pixel.
- pixel_valid  in  1  pixel_in is accepted on this edge; no backpressure.
- window  out  DATA_WIDTH*K*K  packed window; element l = r*K + c occupies bits [DATA_WIDTH*(l+1)-1 : DATA_WIDTH*l]. r=0 is the oldest (top) row and c=0 is the leftmost column. Weights downstream use the same order.
- window_valid  out  1  window holds a new window this cycle; drives the convolution valid.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Counters: col (0..COLUMN_SIZE-1) and row (0..ROW_SIZE-1) advance only on pixel_valid.
  - col wraps to 0 at COLUMN_SIZE-1 and increments row.
  - row wraps to 0 at ROW_SIZE-1 with col=COLUMN_SIZE-1, which ends the frame.
- Line storage: K-1 line buffers of COLUMN_SIZE entries, as shift chains or RAM with a shared column pointer.
  - On an accepted pixel, the buffer for row r-1 supplies column col of row r-1. Older buffers likewise supply rows r-2 .. r-K+1.
  - The new pixel is written in.
  - Line buffer contents are not reset; they are never exposed before being overwritten.
- Window register: KxK registers.
  - On an accepted pixel, each row shifts left by one column.
  - Column K-1 loads the K-1 buffered pixels for column col of rows r-K+1..r-1, plus pixel_in as row K-1.
- State machine:
  - FILL: linear index idx = row*COLUMN_SIZE+col < (K-1)*COLUMN_SIZE + (K-1). No windows are emitted.
  - STREAM: all remaining pixels of the frame. Every accepted pixel emits one window.
  - FILL -> STREAM on accepting pixel (K-1, K-1).
  - STREAM -> FILL on accepting the last pixel (ROW_SIZE-1, COLUMN_SIZE-1).
- Windows for pixels with col >= K-1 cover rows row-K+1..row and columns col-K+1..col.
- Windows for col < K-1 (row >= K) straddle the row wrap. Their contents are don't-care, but they must still assert window_valid.
- Windows emitted per frame: (ROW_SIZE-K+1)*COLUMN_SIZE - (K-1).
- Emission always begins at a row's column K-1, which keeps the downstream column counter aligned across frames.
- Frames are back-to-back. A new frame's pixel (0,0) may arrive the cycle after the previous frame's last pixel.

## Timing
- Latency: window and window_valid are registered and appear one cycle after the accepting edge.
- Output holds:
  - window_valid is high for exactly one cycle per emitted window.
  - window holds its value until the next accepted pixel.
- Gaps: pixel_valid may deassert for any number of cycles. All state freezes and window_valid stays 0.
- frame_done asserts in the same cycle as the final window_valid of the frame.
- Reset values (asynchronous on reset_n low): col=0, row=0, state=FILL, window=0, window_valid=0, frame_done=0.
- Reset mid-frame: a partial frame is abandoned. After release, the next accepted pixel is (0,0), and the FILL phase repeats fully before any window.
- The first pixel may be accepted on the first rising edge after reset_n deasserts.

## Test plan
All scenarios use C=5, R=5, K=3, DATA_WIDTH=16, and pixel value = row*5+col, unless stated otherwise.
- Fill and first window: stream 25 pixels continuously.
  - First window_valid occurs 1 cycle after pixel 12 is accepted.
  - window elements 0..8 = 0,1,2,5,6,7,10,11,12.
- Window count and frame_done: the same stream produces exactly 13 window_valid pulses.
  - Last window = 12,13,14,17,18,19,22,23,24.
  - frame_done is high only in that final window_valid cycle.
- Gaps: insert random 0-4 cycle pixel_valid gaps.
  - The window sequence and values are identical to the continuous case.
  - window_valid is never asserted during a gap.
- Back-to-back frames: two frames with no gap; the second frame uses values +100.
  - 26 windows in total.
  - The second frame's first window = 100,101,102,105,106,107,110,111,112.
  - Downstream modulo-5 count stays aligned: valid windows fall at counts 0-2, masked ones at counts 3-4.
- Reset mid-frame: pull reset_n low after 17 pixels.
  - Outputs are 0 immediately (asynchronously).
  - After release, a fresh 25-pixel frame reproduces the scenario 1 and 2 results exactly.
- Parameter sweep: K=2, C=4, R=3.
  - First window = 0,1,4,5.
  - 7 windows in total.
